fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the MIPS-subset cores.
- Replaces the free-running PC register and the zero-latency instruction ROM read with a request/grant memory interface, a DEPTH-entry prefetch queue and a redirect (branch/jump) path.
- Sits between instruction memory and decode, presenting {instruction, PC} pairs to the consumer with a valid/ready handshake.

---
 rtl/fetch_queue.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end. Issues word-aligned fetch
//               requests on a request/grant memory interface, buffers the
//               in-order responses in a DEPTH-entry circular prefetch queue
//               and presents {instruction, PC} pairs to decode with a
//               valid/ready handshake. A redirect flushes the queue, restarts
//               fetch at the new address and discards responses still in
//               flight for the old path.
//
// Ports       : clock, reset          - clock, asynchronous active-high reset
//               imem_req_out/addr_out - fetch request and address
//               imem_gnt_in           - request accepted when req & gnt
//               imem_rvalid_in/rdata  - in-order instruction responses
//               redirect_in/pc_in     - branch/jump restart
//               ins_valid_out/ins_out/ins_pc_out/ins_ready_in
//                                     - decode-side handshake
//               count_out             - queue occupancy
//
// Options     : FETCH_QUEUE_BYPASS_EN - when defined, a response arriving at
//               an empty queue with the consumer ready is handed straight to
//               the outputs in the same cycle instead of being queued.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0040_0000)
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         imem_req_out,
    output logic [ADDR_WIDTH-1:0]        imem_addr_out,
    input  logic                         imem_gnt_in,
    input  logic                         imem_rvalid_in,
    input  logic [DATA_WIDTH-1:0]        imem_rdata_in,
    input  logic                         redirect_in,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_in,
    output logic                         ins_valid_out,
    output logic [DATA_WIDTH-1:0]        ins_out,
    output logic [ADDR_WIDTH-1:0]        ins_pc_out,
    input  logic                         ins_ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int                    c_PTR_W   = $clog2(DEPTH);
    localparam int                    c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);
    localparam logic [c_CNT_W:0]      c_DEPTH_W = (c_CNT_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_fetch_pc;      // next address to request
    logic [ADDR_WIDTH-1:0] r_resp_pc;       // address of next expected response
    logic [c_CNT_W-1:0]    r_outstanding;   // granted, not yet returned
    logic [c_CNT_W-1:0]    r_drop;          // stale responses left to discard
    logic [c_CNT_W-1:0]    r_count;         // queue occupancy
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_mem_ins [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc  [DEPTH];
    logic [DATA_WIDTH-1:0] r_ins;           // registered head instruction
    logic [ADDR_WIDTH-1:0] r_pc;            // registered head PC

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_CNT_W:0]      w_credit_used;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_resp_live;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [c_PTR_W-1:0]    w_rd_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_CNT_W-1:0]    w_out_nxt;
    logic                  w_head_from_resp;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic                  w_unused_pc_lsb;

    // Queued entries plus in-flight requests never exceed DEPTH, so every
    // returned response is guaranteed a slot.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req         = (w_credit_used < c_DEPTH_W) & ~redirect_in & ~reset;
    assign w_grant       = w_req & imem_gnt_in;

    // A response belongs to the current path only when no stale responses
    // are pending and no redirect is flushing this cycle.
    assign w_resp_live   = imem_rvalid_in & (r_drop == '0) & ~redirect_in;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass      = w_resp_live & (r_count == '0) & ins_ready_in;
`else
    assign w_bypass      = 1'b0;
`endif

    assign w_push        = w_resp_live & ~w_bypass;
    assign w_pop         = (r_count != '0) & ins_ready_in;

    assign w_rd_nxt      = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_cnt_nxt     = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_out_nxt     = r_outstanding + c_CNT_W'(w_grant)
                         - c_CNT_W'(imem_rvalid_in);

    // The next head comes straight from the response when the slot being
    // written is the slot the read pointer lands on (empty queue, or the
    // last entry popped while a new one arrives).
    assign w_head_from_resp = w_push & (r_wr_ptr == w_rd_nxt);

    assign w_redirect_pc    = {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_pc_lsb  = ^redirect_pc_in[1:0];

    // ------------------------------------------------------------------
    // Queue storage (no reset needed: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_ins[r_wr_ptr] <= imem_rdata_in;
            r_mem_pc[r_wr_ptr]  <= r_resp_pc;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_ins         <= '0;
            r_pc          <= '0;
        end else begin
            r_outstanding <= w_out_nxt;

            if (redirect_in) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                // Everything still in flight after this cycle belongs to the
                // old path; this also folds in any earlier pending drops.
                r_drop     <= w_out_nxt;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                end
                if (w_resp_live) begin
                    r_resp_pc <= r_resp_pc + c_PC_STEP;
                end
                if (imem_rvalid_in && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= w_cnt_nxt;
            end

            // Head registers track the entry that will be at the head next
            // cycle; otherwise they hold so the outputs stay stable while
            // invalid.
            if (!redirect_in && (w_cnt_nxt != '0)) begin
                if (w_head_from_resp) begin
                    r_ins <= imem_rdata_in;
                    r_pc  <= r_resp_pc;
                end else begin
                    r_ins <= r_mem_ins[w_rd_nxt];
                    r_pc  <= r_mem_pc[w_rd_nxt];
                end
            end else if (w_bypass) begin
                r_ins <= imem_rdata_in;
                r_pc  <= r_resp_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_out  = w_req;
    assign imem_addr_out = r_fetch_pc;
    assign count_out     = r_count;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign ins_valid_out = (r_count != '0) | w_bypass;
    assign ins_out       = w_bypass ? imem_rdata_in : r_ins;
    assign ins_pc_out    = w_bypass ? r_resp_pc     : r_pc;
`else
    assign ins_valid_out = (r_count != '0);
    assign ins_out       = r_ins;
    assign ins_pc_out    = r_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A memory model answers
//               granted requests in order after a per-request latency; a
//               path model tracks the expected fetch address, credit and
//               the instructions that must reach decode; a monitor pops the
//               scoreboard on every consumer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0040_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_out;
    logic [AW-1:0] imem_addr_out;
    logic          imem_gnt_in    = 1'b0;
    logic          imem_rvalid_in = 1'b0;
    logic [DW-1:0] imem_rdata_in  = '0;
    logic          redirect_in    = 1'b0;
    logic [AW-1:0] redirect_pc_in = '0;
    logic          ins_valid_out;
    logic [DW-1:0] ins_out;
    logic [AW-1:0] ins_pc_out;
    logic          ins_ready_in   = 1'b0;
    logic [2:0]    count_out;

    fetch_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_gnt_in    (imem_gnt_in),
        .imem_rvalid_in (imem_rvalid_in),
        .imem_rdata_in  (imem_rdata_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .ins_valid_out  (ins_valid_out),
        .ins_out        (ins_out),
        .ins_pc_out     (ins_pc_out),
        .ins_ready_in   (ins_ready_in),
        .count_out      (count_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;      // path-model address of this fetch
        logic [31:0] dut_addr;  // address the memory actually saw
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    req_t        inflight[$];
    exp_t        sb[$];
    logic [31:0] popped_pc[$];
    exp_t        mon_e;

    int n_cmp = 0, n_bad = 0, n_pop = 0, n_grant = 0, cyc = 0, epoch = 0;
    int p_gnt = 100, p_ready = 100, lat_min = 1, lat_max = 1;
    logic [31:0] m_pc = RPC;

    function automatic logic [31:0] f_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every consumer handshake must match the oldest expectation.
    always @(negedge clock) begin
        #3;
        if (!reset && ins_valid_out && ins_ready_in) begin
            n_pop++;
            popped_pc.push_back(ins_pc_out);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop @%0t: got pc %0h, expected no instruction", $time, ins_pc_out);
            end else begin
                mon_e = sb.pop_front();
                chk("ins_pc", ins_pc_out, mon_e.pc);
                chk("ins", ins_out, mon_e.ins);
            end
        end
    end

    // One clock cycle of stimulus plus the per-cycle model checks.
    task automatic do_cycle(input bit redir, input logic [31:0] rpc);
        bit resp_now, granted, pushed, exp_req, exp_valid;
        int sz;
        @(negedge clock);
        imem_gnt_in    = ($urandom_range(99) < p_gnt);
        ins_ready_in   = ($urandom_range(99) < p_ready);
        redirect_in    = redir;
        redirect_pc_in = redir ? rpc : $urandom;
        resp_now       = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rvalid_in = resp_now;
        imem_rdata_in  = resp_now ? f_data(inflight[0].dut_addr) : $urandom;
        #1;
        sz      = sb.size();
        exp_req = ((sz + inflight.size()) < DEPTH) && !redir;
        chk("imem_req", imem_req_out, exp_req);
        chk("imem_addr", imem_addr_out, m_pc);
        chk("count", count_out, sz);
        granted = imem_req_out && imem_gnt_in;
        pushed  = 1'b0;
        if (resp_now && !redir && inflight[0].epoch == epoch) begin
            sb.push_back('{ins: f_data(inflight[0].addr), pc: inflight[0].addr});
            pushed = 1'b1;
        end
        #1;
        exp_valid = (sz != 0) || (BYP && pushed && ins_ready_in);
        chk("ins_valid", ins_valid_out, exp_valid);
        #2;
        if (resp_now) void'(inflight.pop_front());
        if (granted) begin
            n_grant++;
            inflight.push_back('{addr: m_pc, dut_addr: imem_addr_out, epoch: epoch,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            epoch++;
            m_pc = {rpc[31:2], 2'b00};
            sb.delete();
            popped_pc.delete();
        end
        cyc++;
    endtask

    task automatic do_reset(input int exp_cnt);
        @(negedge clock);
        if (exp_cnt >= 0) chk("pre_reset_count", count_out, exp_cnt);
        imem_gnt_in    = 1'b0;
        imem_rvalid_in = 1'b0;
        redirect_in    = 1'b0;
        ins_ready_in   = 1'b0;
        reset          = 1'b1;
        #1;
        chk("rst_valid", ins_valid_out, 1'b0);
        chk("rst_count", count_out, 0);
        chk("rst_req", imem_req_out, 1'b0);
        chk("rst_addr", imem_addr_out, RPC);
        chk("rst_ins", ins_out, 0);
        chk("rst_pc", ins_pc_out, 0);
        sb.delete();
        inflight.delete();
        popped_pc.delete();
        epoch++;
        m_pc = RPC;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("first_req", imem_req_out, 1'b1);
        chk("first_addr", imem_addr_out, RPC);
    endtask

    initial begin
        int base;
        int r;

        // Streaming: zero-wait grants, L=1, consumer always ready.
        do_reset(-1);
        p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
        base = n_pop;
        repeat (40) do_cycle(1'b0, '0);
        chk("stream_pops", n_pop - base, 38 + BYP);

        // Stalled consumer: credit limits grants to DEPTH.
        do_reset(-1);
        p_ready = 0;
        base = n_grant;
        repeat (12) do_cycle(1'b0, '0);
        chk("stall_grants", n_grant - base, DEPTH);
        chk("stall_count", count_out, DEPTH);
        chk("stall_req", imem_req_out, 1'b0);
        p_ready = 100;
        do_cycle(1'b0, '0);
        p_ready = 0;
        base = n_grant;
        repeat (10) do_cycle(1'b0, '0);
        chk("refill_grants", n_grant - base, 1);

        // L=3, three requests in flight, redirect to an unaligned address.
        do_reset(-1);
        p_ready = 100; lat_min = 3; lat_max = 3;
        repeat (3) do_cycle(1'b0, '0);
        chk("pre_redir_inflight", inflight.size(), 3);
        do_cycle(1'b1, 32'h0040_0102);
        repeat (12) do_cycle(1'b0, '0);
        if (popped_pc.size() > 0) chk("redir_first_pc", popped_pc[0], 32'h0040_0100);
        else chk("redir_any_pop", popped_pc.size(), 1);

        // Response, redirect and pop all in the same cycle.
        do_reset(-1);
        lat_min = 1; lat_max = 1;
        repeat (6) do_cycle(1'b0, '0);
        do_cycle(1'b1, 32'h0040_0200);
        repeat (10) do_cycle(1'b0, '0);
        if (popped_pc.size() > 0) chk("redir2_first_pc", popped_pc[0], 32'h0040_0200);
        else chk("redir2_any_pop", popped_pc.size(), 1);

        // Reset mid-stream with two entries queued.
        do_reset(-1);
        p_ready = 0;
        repeat (3) do_cycle(1'b0, '0);
        do_reset(2);
        p_ready = 100;
        repeat (8) do_cycle(1'b0, '0);

        // Randomised traffic with redirects and occasional resets.
        p_gnt = 70; p_ready = 65; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(999);
            if (r < 3) do_reset(-1);
            else do_cycle(r < 33, {16'h0040, 16'($urandom)});
        end
        p_gnt = 100; p_ready = 100;
        repeat (20) do_cycle(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
